// File: rtl/trial_controller_if.sv
// Control bundle between trial_controller and the movement stage / reward logic.
//   Inputs to the controller : start, step, move_req, goal_reached
//   Outputs from controller  : active, trialBreak, change_InVec, iTrial, reward, timeout, done
// trialBreak carries the movement.break pulse ("break" is a reserved word in SystemVerilog).
// master = controller side, slave = movement/environment side.
interface trial_controller_if;
    logic       start;
    logic       step;
    logic       move_req;
    logic       goal_reached;
    logic       active;
    logic       trialBreak;
    logic       change_InVec;
    logic [9:0] iTrial;
    logic       reward;
    logic       timeout;
    logic       done;

    modport master (
        input  start, step, move_req, goal_reached,
        output active, trialBreak, change_InVec, iTrial, reward, timeout, done
    );

    modport slave (
        output start, step, move_req, goal_reached,
        input  active, trialBreak, change_InVec, iTrial, reward, timeout, done
    );
endinterface

// File: rtl/trial_controller.sv
// trial_controller: sequences navigation trials in front of the movement stage.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : trial_controller_if.master
//           start (session start, IDLE only), step (time-step tick), move_req (move request),
//           goal_reached (level) in; active, trialBreak, change_InVec, iTrial[9:0], reward,
//           timeout, done out.
// Every output is a Moore output registered from the next state, so it is glitch-free and
// lines up with the registered state cycle for cycle.
module trial_controller #(
    parameter int unsigned STEPS_TIMEOUT = 1000,
    parameter int unsigned MAX_MOVES     = 4,
    parameter int unsigned ITI_STEPS     = 20,
    parameter int unsigned N_TRIALS      = 500
) (
    input logic                 clk,
    input logic                 reset,
    trial_controller_if.master  bus
);

    localparam int unsigned StepMax = (STEPS_TIMEOUT > ITI_STEPS) ? STEPS_TIMEOUT : ITI_STEPS;
    localparam int unsigned StepW   = $clog2(StepMax + 1);
    localparam int unsigned MoveW   = $clog2(MAX_MOVES + 1);

    localparam logic [StepW-1:0] StepTimeoutLast = StepW'(STEPS_TIMEOUT - 1);
    localparam logic [StepW-1:0] ItiLast         = StepW'(ITI_STEPS - 1);
    localparam logic [MoveW-1:0] MovesMax        = MoveW'(MAX_MOVES);
    localparam logic [9:0]       TrialLast       = 10'(N_TRIALS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StRun,
        StMove,
        StSettle,
        StReward,
        StAbort,
        StIti,
        StDone
    } stateT;

    stateT            stateQ, stateD;
    logic [StepW-1:0] stepCntQ, stepCntD;
    logic [MoveW-1:0] moveCntQ, moveCntD;
    logic [9:0]       iTrialQ, iTrialD;

    logic activeQ, breakQ, changeQ, rewardQ, timeoutQ, doneQ;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ   <= StIdle;
            stepCntQ <= '0;
            moveCntQ <= '0;
            iTrialQ  <= '0;
            activeQ  <= 1'b0;
            breakQ   <= 1'b0;
            changeQ  <= 1'b0;
            rewardQ  <= 1'b0;
            timeoutQ <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            stepCntQ <= stepCntD;
            moveCntQ <= moveCntD;
            iTrialQ  <= iTrialD;
            activeQ  <= (stateD == StRun);
            breakQ   <= (stateD == StInit);
            changeQ  <= (stateD == StMove);
            rewardQ  <= (stateD == StReward);
            timeoutQ <= (stateD == StAbort);
            doneQ    <= (stateD == StDone);
        end
    end

    always_comb begin
        stateD   = stateQ;
        stepCntD = stepCntQ;
        moveCntD = moveCntQ;
        iTrialD  = iTrialQ;

        unique case (stateQ)
            StIdle: begin
                if (bus.start) stateD = StInit;
            end
            StInit: begin
                stepCntD = '0;
                moveCntD = '0;
                stateD   = StRun;
            end
            StRun: begin
                // Goal beats a move, and a move beats a coincident timeout tick.
                if (bus.goal_reached) begin
                    stateD = StReward;
                end else if (bus.move_req) begin
                    stateD = (moveCntQ < MovesMax) ? StMove : StAbort;
                end else if (bus.step) begin
                    if (stepCntQ == StepTimeoutLast) stateD = StAbort;
                    else                             stepCntD = stepCntQ + StepW'(1);
                end
            end
            StMove: begin
                moveCntD = moveCntQ + MoveW'(1);
                stepCntD = '0;
                stateD   = StSettle;
            end
            StSettle: begin
                // Idle cycle so InVec is stable before integration resumes.
                stateD = StRun;
            end
            StReward, StAbort: begin
                stepCntD = '0;
                stateD   = StIti;
            end
            StIti: begin
                if (bus.step) begin
                    if (stepCntQ == ItiLast) begin
                        if (iTrialQ == TrialLast) begin
                            stateD = StDone;
                        end else begin
                            iTrialD = iTrialQ + 10'd1;
                            stateD  = StInit;
                        end
                    end else begin
                        stepCntD = stepCntQ + StepW'(1);
                    end
                end
            end
            StDone: begin
                stateD = StDone;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign bus.active       = activeQ;
    assign bus.trialBreak   = breakQ;
    assign bus.change_InVec = changeQ;
    assign bus.reward       = rewardQ;
    assign bus.timeout      = timeoutQ;
    assign bus.done         = doneQ;
    assign bus.iTrial       = iTrialQ;

endmodule

// File: tb/tb_trial_controller.sv
// Bench for trial_controller: a per-cycle vector table plus directed multi-cycle sequences.
// Output vector ordering: {active, trialBreak, change_InVec, reward, timeout, done}.
module tb_trial_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trial_controller_if bus();

    trial_controller #(
        .STEPS_TIMEOUT (5),
        .MAX_MOVES     (4),
        .ITI_STEPS     (4),
        .N_TRIALS      (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [5:0] outs = {bus.active, bus.trialBreak, bus.change_InVec,
                       bus.reward, bus.timeout, bus.done};

    localparam logic [5:0] ONone   = 6'b000000;
    localparam logic [5:0] OActive = 6'b100000;
    localparam logic [5:0] OBreak  = 6'b010000;
    localparam logic [5:0] OChange = 6'b001000;
    localparam logic [5:0] OReward = 6'b000100;
    localparam logic [5:0] OTmo    = 6'b000010;
    localparam logic [5:0] ODone   = 6'b000001;

    typedef struct packed {
        logic       rn;
        logic       st;
        logic       sp;
        logic       mv;
        logic       gl;
        logic [5:0] out;
        logic [9:0] it;
    } vecT;

    int nChecks = 0;
    int nPass   = 0;
    int chgCount;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Apply inputs, let one rising edge take them, then settle before sampling.
    task automatic cyc(input logic rn, input logic st, input logic sp, input logic mv,
                       input logic gl);
        reset            = rn;
        bus.start        = st;
        bus.step         = sp;
        bus.move_req     = mv;
        bus.goal_reached = gl;
        @(posedge clk);
        #1;
        if (bus.change_InVec) chgCount++;
    endtask

    task automatic chkOut(input string name, input logic [5:0] exp, input logic [9:0] expIt);
        chk(name, {outs, bus.iTrial}, {exp, expIt});
    endtask

    vecT tbl[17];

    initial begin
        reset = 1'b0;
        bus.start = 1'b0;
        bus.step = 1'b0;
        bus.move_req = 1'b0;
        bus.goal_reached = 1'b0;
        chgCount = 0;

        //            rn    st    sp    mv    gl    out      it
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONone,   10'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ONone,   10'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONone,   10'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OBreak,  10'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, OActive, 10'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, OChange, 10'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, ONone,   10'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OActive, 10'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, OActive, 10'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, OReward, 10'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ONone,   10'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ONone,   10'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ONone,   10'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ONone,   10'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, OBreak,  10'd1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OActive, 10'd1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, OReward, 10'd1};

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].rn, tbl[i].st, tbl[i].sp, tbl[i].mv, tbl[i].gl);
            chkOut($sformatf("vec%0d", i), tbl[i].out, tbl[i].it);
        end

        // Move sequencing and exhaustion.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chkOut("mv_run", OActive, 10'd0);
        chgCount = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chkOut($sformatf("mv%0d_pulse", k), OChange, 10'd0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut($sformatf("mv%0d_settle", k), ONone, 10'd0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut($sformatf("mv%0d_resume", k), OActive, 10'd0);
            for (int j = 0; j < 7; j++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chkOut("mv5_abort", OTmo, 10'd0);
        chk("mv_pulse_count", 16'(chgCount), 16'd4);

        // Step timeout after 5 ticks, then a 4-tick ITI into trial 1.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chkOut($sformatf("to_tick%0d", t), OActive, 10'd0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chkOut("to_tick5", OTmo, 10'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 3; t++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            chkOut($sformatf("iti_tick%0d", t), ONone, 10'd0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chkOut("iti_end_break", OBreak, 10'd1);

        // Session end with goal held: breaks at iTrial 0,1,2 then done.
        begin
            logic [9:0] seen[4];
            int         nSeen;
            int         budget;
            nSeen = 0;
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            budget = 0;
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            while (!bus.done && budget < 80) begin
                if (bus.trialBreak && nSeen < 4) begin
                    seen[nSeen] = bus.iTrial;
                    nSeen++;
                end
                cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
                budget++;
            end
            chk("sess_done", {15'd0, bus.done}, 16'd1);
            chk("sess_breaks", 16'(nSeen), 16'd3);
            for (int i = 0; i < 3; i++) begin
                if (i < nSeen) chk($sformatf("sess_trial%0d", i), {6'd0, seen[i]}, 16'(i));
            end
            chkOut("sess_done_out", ODone, 10'd2);
            for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            chkOut("sess_start_ignored", ODone, 10'd2);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut("sess_reset", ONone, 10'd0);
        end

        // Mid-trial reset while in SETTLE of trial 2.
        begin
            int budget;
            budget = 0;
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            while (!(bus.trialBreak && bus.iTrial == 10'd2) && budget < 60) begin
                cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
                budget++;
            end
            chkOut("mr_trial2_break", OBreak, 10'd2);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chkOut("mr_move", OChange, 10'd2);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut("mr_settle", ONone, 10'd2);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut("mr_reset", ONone, 10'd0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chkOut("mr_idle1", ONone, 10'd0);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            chkOut("mr_idle2", ONone, 10'd0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
